// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the 5-stage RV32I pipeline.
// Tracks in-flight destinations, sequences SYSTEM halt, counts stall cycles.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwen,
    input  logic             id_is_load,
    input  logic             id_is_system,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;

    logic [4:0] ex_rd, mem_rd;
    logic       ex_wr, ex_ld, mem_wr;

    logic freeze, ex_eff, mem_eff, load_use;
    logic [4:0] en;

    assign freeze  = mem_req & ~mem_ready;
    assign ex_eff  = ex_wr & (ex_rd != 5'd0);
    assign mem_eff = mem_wr & (mem_rd != 5'd0);

    assign load_use = id_valid & ex_ld & ex_eff &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign halted = (state_q == HALTED);

    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (uses && ex_eff && rs == ex_rd)
            sel = 2'b01;
        else if (uses && mem_eff && rs == mem_rd)
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        en           = 5'b00000;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        state_d      = state_q;
        drain_d      = drain_q;
        if (rst_n) begin
            unique case (state_q)
                RUN: begin
                    if (freeze) begin
                        en = 5'b00000;
                    end else if (ex_redirect) begin
                        en           = 5'b11111;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        en           = 5'b00111;
                        id_ex_bubble = 1'b1;
                    end else if (id_valid && id_is_system) begin
                        en          = 5'b11111;
                        if_id_flush = 1'b1;
                        state_d     = DRAIN;
                        drain_d     = DW'(DRAIN_CYCLES);
                    end else begin
                        en = 5'b11111;
                    end
                end
                DRAIN: begin
                    if (!freeze) begin
                        en           = 5'b00111;
                        id_ex_bubble = 1'b1;
                        // halt lands on the edge that consumes the last drain slot
                        if (drain_q <= DW'(1)) begin
                            state_d = HALTED;
                            drain_d = '0;
                        end else begin
                            drain_d = drain_q - DW'(1);
                        end
                    end
                end
                HALTED: begin
                    en = 5'b00000;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            drain_q      <= '0;
            ex_rd        <= 5'd0;
            ex_wr        <= 1'b0;
            ex_ld        <= 1'b0;
            mem_rd       <= 5'd0;
            mem_wr       <= 1'b0;
            fwd_a        <= 2'b00;
            fwd_b        <= 2'b00;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            if (id_ex_en) begin
                if (id_ex_bubble || !id_valid) begin
                    ex_rd <= 5'd0;
                    ex_wr <= 1'b0;
                    ex_ld <= 1'b0;
                end else begin
                    ex_rd <= id_rd;
                    ex_wr <= id_regwen;
                    ex_ld <= id_is_load;
                end
                fwd_a <= id_ex_bubble ? 2'b00 : fwd_sel(id_uses_rs1, id_rs1);
                fwd_b <= id_ex_bubble ? 2'b00 : fwd_sel(id_uses_rs2, id_rs2);
            end
            if (ex_mem_en) begin
                mem_rd <= ex_rd;
                mem_wr <= ex_wr;
            end
            if (!pc_en && state_q != HALTED)
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It sits beside the decoder and the IF/ID/EX/MEM/WB pipeline registers. From the ID-stage decode fields, the EX-stage redirect and the data-memory handshake, it generates per-stage register enables, flush/bubble controls and registered forwarding selects. It keeps its own shadow copy of destination registers in flight, sequences halt on SYSTEM/FENCE, and counts stall cycles.

## Interface
Parameters:
- DRAIN_CYCLES, default 3: non-frozen cycles between a SYSTEM instruction entering EX and `halted` asserting.
- CNT_W, default 32: width of `stall_cycles`.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- id_valid  in  1  ID stage holds a valid instruction.
- id_rs1, id_rs2  in  5  ID source registers.
- id_uses_rs1, id_uses_rs2  in  1  the source is actually read (for example, LUI/JAL use neither).
- id_rd  in  5  ID destination register.
- id_regwen  in  1  ID instruction writes `rd`.
- id_is_load  in  1  ID instruction is a LOAD.
- id_is_system  in  1  ID opcode is SYSTEM or FENCE.
- ex_redirect  in  1  branch taken or JAL/JALR resolved in EX this cycle.
- mem_req  in  1  MEM-stage instruction is accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register enables.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX (takes effect only when `id_ex_en`=1).
- fwd_a, fwd_b  out  2 each  operand source for the instruction in EX. 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
- halted  out  1  core halted.
- stall_cycles  out  CNT_W  count of cycles with `pc_en`=0, excluding HALTED.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset state is RUN.
- Shadow registers:
  - ex_rd/ex_wr/ex_ld: load from ID on `id_ex_en`. A bubble, or `id_valid`=0, loads zeros.
  - mem_rd/mem_wr: load from ex_* on `ex_mem_en`.
  - A write is "effective" only when wr=1 and rd≠0.
- Priority in RUN, evaluated each cycle:
  1. Freeze, when `mem_req & !mem_ready`: all five enables are 0, no flush or bubble, and all state holds.
  2. Redirect, when `ex_redirect`: all enables are 1, `if_id_flush`=1 and `id_ex_bubble`=1. The ID instruction is squashed, so load-use and SYSTEM checks are ignored.
  3. Load-use, when `id_valid` & ex_ld & the EX write is effective & (`uses_rs1` & rs1==ex_rd | `uses_rs2` & rs2==ex_rd):
     - `pc_en`=0 and `if_id_en`=0.
     - `id_ex_en`=1 with `id_ex_bubble`=1.
     - `ex_mem_en`=1 and `mem_wb_en`=1.
  4. SYSTEM, when `id_valid & id_is_system`: all enables are 1 and `if_id_flush`=1. The SYSTEM instruction advances to EX. The FSM goes to DRAIN with the drain counter set to DRAIN_CYCLES.
  5. Otherwise all enables are 1 and there is no flush.
- DRAIN:
  - `pc_en`=0 and `if_id_en`=0.
  - `id_ex_bubble`=1 with `id_ex_en`=1.
  - `ex_mem_en`=1 and `mem_wb_en`=1.
  - Freeze still overrides and pauses the counter.
  - The counter decrements on each non-frozen cycle. On the cycle it reaches 0, the FSM goes to HALTED.
  - `ex_redirect` is ignored in DRAIN.
- HALTED: all enables are 0 and `halted`=1. The FSM leaves only on reset.
- Forwarding is computed for the ID instruction and registered into fwd_a/fwd_b when `id_ex_en`=1:
  - Match on the effective EX write → 01.
  - Otherwise match on the effective MEM write → 10.
  - Otherwise 00.
  - `uses_rsN`=0 or a bubble → 00.
  - fwd_* hold when `id_ex_en`=0.
- The register file is write-before-read. A WB-stage producer is not forwarded.
- `stall_cycles` increments when `pc_en`=0 and the state is not HALTED. It wraps modulo 2^CNT_W.

## Timing
- While `rst_n`=0:
  - All enables are 0; flush and bubble are 0.
  - fwd_a and fwd_b = 00.
  - `halted`=0 and `stall_cycles`=0.
  - State is RUN and all shadow registers are 0.
- Enables, flush and bubble are combinational from the current state and inputs, with zero latency.
- fwd_*, shadow registers, `halted` and `stall_cycles` are registered and update on the rising clk edge.
- The load-use stall is exactly 1 cycle. The dependent instruction then sees fwd=10.
- A redirect costs 2 squashed slots, applied in the same cycle as `ex_redirect`.
- Freeze lasts exactly as long as `mem_req & !mem_ready`. The cycle in which `mem_ready`=1 is a normal cycle.
- Reset asserted mid-DRAIN or in HALTED returns the block immediately to RUN with all outputs at their reset values.

## Test plan
- Load-use: LW x5 in EX (ex_ld=1, ex_rd=5); ID ADD with rs1=5, `uses_rs1`=1 → 1 cycle with `pc_en`=0, `if_id_en`=0 and bubble=1; next cycle fwd_a=10; `stall_cycles`=1.
- Forward priority: EX writes x7 and MEM writes x7; ID instruction has rs2=7 → fwd_b=01. Producer with rd=0 → fwd_b=00.
- Redirect with simultaneous load-use: `ex_redirect`=1 → `if_id_flush`=1, bubble=1, all enables 1, no stall counted.
- Memory freeze: `mem_req`=1 with `mem_ready`=0 for 3 cycles → enables 0 for 3 cycles, fwd held, `stall_cycles`=3; release cycle behaves normally.
- SYSTEM halt: ECALL in ID, DRAIN_CYCLES=3, one freeze cycle inserted during DRAIN → `halted`=1 on the 5th edge after the ECALL cycle; `stall_cycles` stops there.
- Reset in HALTED: `rst_n`=0 asynchronously → `halted`=0 immediately; after release, state is RUN and the enables are 1.
